// File: rtl/uart_pkg.sv
// Shared definitions for the parameterised UART: FSM states, parity modes and
// data-bit encodings, reused by the TX top and the future RX.
package uart_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP1  = 3'd4,
        ST_STOP2  = 3'd5
    } state_t;

    localparam logic [1:0] PAR_NONE = 2'b00;
    localparam logic [1:0] PAR_EVEN = 2'b01;
    localparam logic [1:0] PAR_ODD  = 2'b10;
    localparam logic [1:0] PAR_MARK = 2'b11;

    localparam logic [1:0] DBITS_5 = 2'b00;
    localparam logic [1:0] DBITS_6 = 2'b01;
    localparam logic [1:0] DBITS_7 = 2'b10;
    localparam logic [1:0] DBITS_8 = 2'b11;

    function automatic logic [3:0] nbits_decode(input logic [1:0] code);
        logic [3:0] n;
        case (code)
            DBITS_5: n = 4'd5;
            DBITS_6: n = 4'd6;
            DBITS_7: n = 4'd7;
            DBITS_8: n = 4'd8;
            default: n = 4'd8;
        endcase
        return n;
    endfunction

endpackage

// File: rtl/uart_sync_fifo.sv
// Single-clock first-word-fall-through FIFO with occupancy count; pushes when
// full and pops when empty are ignored.
module uart_sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int LVL_W = $clog2(DEPTH) + 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] pop_data,
    output logic             full,
    output logic             empty,
    output logic [LVL_W-1:0] level
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign full     = (level == LVL_W'(DEPTH));
    assign empty    = (level == '0);
    assign do_push  = push && !full;
    assign do_pop   = pop && !empty;
    assign pop_data = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= push_data;
        end
    end

    // DEPTH is a power of two, so the pointers wrap on their own
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({do_push, do_pop})
                2'b10:   level <= level + LVL_W'(1);
                2'b01:   level <= level - LVL_W'(1);
                default: level <= level;
            endcase
        end
    end

endmodule

// File: rtl/uart_tx_param.sv
// Runtime-configurable UART transmitter (5-8 data bits, none/even/odd/mark
// parity, 1 or 2 stop bits, run-time baud divisor) fed from a small FIFO.
//
//  state  | meaning
//  IDLE   | line high, waiting for a queued byte
//  START  | start bit (low)
//  DATA   | data bits, LSB first, bit_idx selects the bit
//  PARITY | parity bit (even / odd / mark)
//  STOP1  | first stop bit (high)
//  STOP2  | optional second stop bit (high)
module uart_tx_param
    import uart_pkg::*;
#(
    parameter int DIV_W      = 16,
    parameter int FIFO_DEPTH = 4,
    localparam int LVL_W     = $clog2(FIFO_DEPTH) + 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [DIV_W-1:0] cfg_div,
    input  logic [1:0]       cfg_data_bits,
    input  logic [1:0]       cfg_parity,
    input  logic             cfg_stop2,
    input  logic             s_valid,
    input  logic [7:0]       s_data,
    output logic             s_ready,
    output logic             tx,
    output logic             busy,
    output logic [LVL_W-1:0] fifo_level
);

    logic             fifo_push;
    logic             fifo_pop;
    logic             fifo_full;
    logic             fifo_empty;
    logic [7:0]       fifo_data;

    state_t           state;
    logic [DIV_W-1:0] cnt;
    logic [DIV_W-1:0] f_div;
    logic [DIV_W-1:0] div_eff;
    logic [2:0]       bit_idx;
    logic [2:0]       f_last;
    logic [7:0]       f_data;
    logic [1:0]       f_par;
    logic             f_stop2;
    logic [3:0]       nbits_cfg;
    logic [7:0]       load_mask;
    logic             last_clk;
    logic             frame_end;
    logic             tx_bit;

    uart_sync_fifo #(
        .WIDTH (8),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (fifo_push),
        .push_data (s_data),
        .pop       (fifo_pop),
        .pop_data  (fifo_data),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .level     (fifo_level)
    );

    assign s_ready   = !fifo_full;
    assign fifo_push = s_valid && s_ready;

    assign nbits_cfg = nbits_decode(cfg_data_bits);
    assign load_mask = 8'hFF >> (4'd8 - nbits_cfg);
    assign div_eff   = (cfg_div < DIV_W'(2)) ? DIV_W'(2) : cfg_div;

    assign last_clk  = (cnt == f_div - DIV_W'(1));
    assign frame_end = last_clk &&
                       ((state == ST_STOP2) || (state == ST_STOP1 && !f_stop2));
    // Popping at frame end chains the next frame with no idle bit
    assign fifo_pop  = !fifo_empty && ((state == ST_IDLE) || frame_end);

    // Upper data bits are masked at load, so parity can reduce all 8 bits
    always_comb begin
        tx_bit = 1'b1;
        case (state)
            ST_START:  tx_bit = 1'b0;
            ST_DATA:   tx_bit = f_data[bit_idx];
            ST_PARITY: begin
                case (f_par)
                    PAR_EVEN: tx_bit = ^f_data;
                    PAR_ODD:  tx_bit = ~^f_data;
                    PAR_MARK: tx_bit = 1'b1;
                    default:  tx_bit = 1'b1;
                endcase
            end
            default:   tx_bit = 1'b1;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= ST_IDLE;
            cnt     <= '0;
            bit_idx <= '0;
            f_div   <= DIV_W'(2);
            f_last  <= 3'd7;
            f_data  <= '0;
            f_par   <= PAR_NONE;
            f_stop2 <= 1'b0;
            busy    <= 1'b0;
            tx      <= 1'b1;
        end else begin
            tx <= tx_bit;
            if (fifo_pop) begin
                state   <= ST_START;
                cnt     <= '0;
                bit_idx <= '0;
                f_div   <= div_eff;
                f_last  <= 3'(nbits_cfg - 4'd1);
                f_data  <= fifo_data & load_mask;
                f_par   <= cfg_parity;
                f_stop2 <= cfg_stop2;
                busy    <= 1'b1;
            end else if (state != ST_IDLE) begin
                if (!last_clk) begin
                    cnt <= cnt + DIV_W'(1);
                end else begin
                    cnt <= '0;
                    case (state)
                        ST_START: state <= ST_DATA;
                        ST_DATA: begin
                            if (bit_idx == f_last) begin
                                state <= (f_par == PAR_NONE) ? ST_STOP1 : ST_PARITY;
                            end else begin
                                bit_idx <= bit_idx + 3'd1;
                            end
                        end
                        ST_PARITY: state <= ST_STOP1;
                        ST_STOP1: begin
                            if (f_stop2) begin
                                state <= ST_STOP2;
                            end else begin
                                state <= ST_IDLE;
                                busy  <= 1'b0;
                            end
                        end
                        ST_STOP2: begin
                            state <= ST_IDLE;
                            busy  <= 1'b0;
                        end
                        default: begin
                            state <= ST_IDLE;
                            busy  <= 1'b0;
                        end
                    endcase
                end
            end
        end
    end

endmodule

// File: tb/tb_uart_tx_param.sv
// Bench for uart_tx_param: a frame-level model predicts tx/busy/level/ready each
// cycle, and directed tests pin bit patterns, latency and frame lengths.
module tb_uart_tx_param;

    localparam int DIV_W = 16;
    localparam int DEPTH = 4;
    localparam int LVL_W = $clog2(DEPTH) + 1;

    logic             clk;
    logic             rst_n;
    logic [DIV_W-1:0] cfg_div;
    logic [1:0]       cfg_data_bits;
    logic [1:0]       cfg_parity;
    logic             cfg_stop2;
    logic             s_valid;
    logic [7:0]       s_data;
    logic             s_ready;
    logic             tx;
    logic             busy;
    logic [LVL_W-1:0] fifo_level;

    int n_pass = 0;
    int n_total = 0;

    uart_tx_param #(.DIV_W(DIV_W), .FIFO_DEPTH(DEPTH)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .cfg_div       (cfg_div),
        .cfg_data_bits (cfg_data_bits),
        .cfg_parity    (cfg_parity),
        .cfg_stop2     (cfg_stop2),
        .s_valid       (s_valid),
        .s_data        (s_data),
        .s_ready       (s_ready),
        .tx            (tx),
        .busy          (busy),
        .fifo_level    (fifo_level)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    // ---------------- frame-level reference model ----------------
    logic [7:0] mq[$];
    logic       txq[$];
    logic       m_tx = 1'b1;
    bit         m_active = 1'b0;
    int         m_left = 0;
    bit         do_push;
    logic [7:0] pop_byte;

    // Expands one byte into its per-clock line levels using the current config
    function automatic int append_frame(input logic [7:0] d);
        logic bits[$];
        int de, nb, ones;
        de = (cfg_div < 16'd2) ? 2 : int'(cfg_div);
        nb = 5 + int'(cfg_data_bits);
        ones = 0;
        bits.push_back(1'b0);
        for (int i = 0; i < nb; i++) begin
            bits.push_back(d[i]);
            ones += int'(d[i]);
        end
        case (cfg_parity)
            2'b01:   bits.push_back((ones % 2) == 1);
            2'b10:   bits.push_back((ones % 2) == 0);
            2'b11:   bits.push_back(1'b1);
            default: ;
        endcase
        bits.push_back(1'b1);
        if (cfg_stop2) bits.push_back(1'b1);
        foreach (bits[k])
            for (int r = 0; r < de; r++) txq.push_back(bits[k]);
        return bits.size() * de;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mq.delete();
            txq.delete();
            m_tx = 1'b1;
            m_active = 1'b0;
            m_left = 0;
        end else begin
            do_push = s_valid && (mq.size() != DEPTH);
            m_tx = (txq.size() > 0) ? txq.pop_front() : 1'b1;
            if (m_active) begin
                m_left--;
                if (m_left == 0) m_active = 1'b0;
            end
            if (!m_active && mq.size() > 0) begin
                pop_byte = mq.pop_front();
                m_left = append_frame(pop_byte);
                m_active = 1'b1;
            end
            if (do_push) mq.push_back(s_data);
        end
    end

    always @(negedge clk) begin
        if (rst_n) begin
            check("tx", 32'(tx), 32'(m_tx));
            check("busy", 32'(busy), 32'(m_active));
            check("fifo_level", 32'(fifo_level), 32'(mq.size()));
            check("s_ready", 32'(s_ready), 32'(mq.size() != DEPTH));
        end
    end

    // Length of the most recent contiguous busy run, and full-FIFO observation
    int  run = 0;
    int  last_run = 0;
    bit  seen_full = 1'b0;
    always @(negedge clk) begin
        if (busy === 1'b1) run++;
        else if (run != 0) begin
            last_run = run;
            run = 0;
        end
        if (fifo_level == LVL_W'(DEPTH) && s_ready === 1'b0) seen_full = 1'b1;
    end

    // ---------------- stimulus helpers ----------------
    logic [7:0] wbuf [8];

    task automatic push_one(input logic [7:0] d);
        s_valid = 1'b1;
        s_data  = d;
        @(negedge clk);
        s_valid = 1'b0;
    endtask

    task automatic push_words(input int n);
        int i = 0;
        int guard = 0;
        logic rdy;
        while (i < n && guard < 1000) begin
            s_valid = 1'b1;
            s_data  = wbuf[i];
            rdy = s_ready;
            @(negedge clk);
            if (rdy) i++;
            guard++;
        end
        s_valid = 1'b0;
        check("push_timeout", 32'(guard >= 1000), 32'd0);
    endtask

    // Waits for the start bit, then samples the middle of each bit period
    task automatic capture(input int de, input int nsmp, output logic [15:0] bits, output int lat);
        bits = '0;
        lat = 0;
        while (tx !== 1'b0 && lat < 50) begin
            @(negedge clk);
            lat++;
        end
        repeat (de / 2) @(negedge clk);
        bits[0] = tx;
        for (int k = 1; k < nsmp; k++) begin
            repeat (de) @(negedge clk);
            bits[k] = tx;
        end
    endtask

    task automatic wait_idle();
        int guard = 0;
        while ((busy !== 1'b0 || fifo_level != '0 || tx !== 1'b1) && guard < 3000) begin
            @(negedge clk);
            guard++;
        end
        repeat (2) @(negedge clk);
        check("idle_timeout", 32'(guard >= 3000), 32'd0);
    endtask

    task automatic set_cfg(input int div, input logic [1:0] db, input logic [1:0] par, input logic st2);
        cfg_div       = DIV_W'(div);
        cfg_data_bits = db;
        cfg_parity    = par;
        cfg_stop2     = st2;
    endtask

    logic [15:0] bits;
    int          lat;
    int          lowcnt;

    initial begin
        rst_n = 1'b0;
        s_valid = 1'b0;
        s_data = 8'h00;
        set_cfg(4, 2'b11, 2'b00, 1'b0);
        repeat (3) @(negedge clk);
        check("rst_tx", 32'(tx), 32'd1);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_level", 32'(fifo_level), 32'd0);
        check("rst_ready", 32'(s_ready), 32'd1);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // 1: div 4, 8N1, 0x55
        set_cfg(4, 2'b11, 2'b00, 1'b0);
        push_one(8'h55);
        capture(4, 10, bits, lat);
        check("t1_latency", 32'(lat), 32'd2);
        check("t1_bits", 32'(bits), 32'h2AA);
        wait_idle();
        check("t1_busy_len", 32'(last_run), 32'd40);

        // 2: div 8, 7E2, 0x41
        set_cfg(8, 2'b10, 2'b01, 1'b1);
        push_one(8'h41);
        capture(8, 11, bits, lat);
        check("t2_latency", 32'(lat), 32'd2);
        check("t2_bits", 32'(bits), 32'h682);
        wait_idle();
        check("t2_busy_len", 32'(last_run), 32'd88);

        // 3: div 2, 5O1, 0xFF
        set_cfg(2, 2'b00, 2'b10, 1'b0);
        push_one(8'hFF);
        capture(2, 8, bits, lat);
        check("t3_latency", 32'(lat), 32'd2);
        check("t3_bits", 32'(bits), 32'h0BE);
        wait_idle();
        check("t3_busy_len", 32'(last_run), 32'd16);

        // 4: div 2, 8N1, six words with s_valid held
        set_cfg(2, 2'b11, 2'b00, 1'b0);
        wbuf[0] = 8'h11; wbuf[1] = 8'h22; wbuf[2] = 8'h33;
        wbuf[3] = 8'h44; wbuf[4] = 8'h55; wbuf[5] = 8'h66;
        seen_full = 1'b0;
        push_words(6);
        wait_idle();
        check("t4_seen_full", 32'(seen_full), 32'd1);
        check("t4_busy_len", 32'(last_run), 32'd120);

        // 5: reset during DATA bit 3 with two words queued
        set_cfg(4, 2'b11, 2'b00, 1'b0);
        wbuf[0] = 8'hC3; wbuf[1] = 8'h5A; wbuf[2] = 8'h0F;
        push_words(3);
        repeat (16) @(negedge clk);
        check("t5_level_before", 32'(fifo_level), 32'd2);
        #2 rst_n = 1'b0;
        #1;
        check("t5_tx", 32'(tx), 32'd1);
        check("t5_busy", 32'(busy), 32'd0);
        check("t5_level", 32'(fifo_level), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        lowcnt = 0;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            if (tx !== 1'b1 || busy !== 1'b0) lowcnt++;
        end
        check("t5_quiet_after", 32'(lowcnt), 32'd0);

        // 6: config change mid-frame affects only the queued frame
        set_cfg(4, 2'b11, 2'b00, 1'b0);
        wbuf[0] = 8'hA5; wbuf[1] = 8'h3C;
        push_words(2);
        repeat (10) @(negedge clk);
        cfg_div = DIV_W'(6);
        cfg_parity = 2'b01;
        wait_idle();
        check("t6_busy_len", 32'(last_run), 32'd106);

        // 7: cfg_div = 0 behaves as 2
        set_cfg(0, 2'b11, 2'b00, 1'b0);
        push_one(8'hA3);
        capture(2, 10, bits, lat);
        check("t7_latency", 32'(lat), 32'd2);
        check("t7_bits", 32'(bits), 32'h346);
        wait_idle();
        check("t7_busy_len", 32'(last_run), 32'd20);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL global_timeout: simulation did not finish, passed %0d of %0d", n_pass, n_total);
        $fatal(1, "timeout");
    end

endmodule
